// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - button debounce with press/release pulses, switch synchroniser
//
// Conditions raw push-buttons and slider switches for the shift-add multiplier.
// Ports:
//   Clk      system clock, rising edge
//   Reset    asynchronous active-low reset
//   Btn_n    raw push-buttons, active-low, asynchronous to Clk
//   SW       raw slider switches, asynchronous to Clk
//   Level    debounced button state, active-high
//   Press    one-cycle pulse on Level 0->1
//   Release  one-cycle pulse on Level 1->0
//   SW_sync  two-flop synchronised switch value
module input_conditioner #(
    parameter int NUM_BTN         = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SW_WIDTH        = 8,
    localparam int CNT_W          = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [NUM_BTN-1:0]  Btn_n,
    input  logic [SW_WIDTH-1:0] SW,
    output logic [NUM_BTN-1:0]  Level,
    output logic [NUM_BTN-1:0]  Press,
    output logic [NUM_BTN-1:0]  Release,
    output logic [SW_WIDTH-1:0] SW_sync
);

    // Count value on which a differing sample is finally accepted.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_BTN-1:0]  btn_s1;
    logic [NUM_BTN-1:0]  btn_s2;
    logic [NUM_BTN-1:0]  sample;
    logic [SW_WIDTH-1:0] sw_s1;
    logic [SW_WIDTH-1:0] sw_s2;
    logic [CNT_W-1:0]    cnt [NUM_BTN];

    // Active-high view of the synchronised buttons.
    assign sample  = ~btn_s2;
    assign SW_sync = sw_s2;

    // Button sync flops reset to the unpressed (high) level so that a button
    // held through reset is seen as a fresh press afterwards.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            btn_s1 <= '1;
            btn_s2 <= '1;
            sw_s1  <= '0;
            sw_s2  <= '0;
        end else begin
            btn_s1 <= Btn_n;
            btn_s2 <= btn_s1;
            sw_s1  <= SW;
            sw_s2  <= sw_s1;
        end
    end

    // Each bit debounces independently. Any sample that agrees with Level
    // restarts the count; the counter is cleared on acceptance, so it never
    // passes CNT_LAST.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            Level   <= '0;
            Press   <= '0;
            Release <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            Press   <= '0;
            Release <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                if (sample[i] == Level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    Level[i]   <= sample[i];
                    Press[i]   <= sample[i];
                    Release[i] <= ~sample[i];
                    cnt[i]     <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - scoreboard bench for input_conditioner
module tb_input_conditioner;

    localparam int NB  = 2;
    localparam int DEB = 4;
    localparam int SWW = 8;

    logic           Clk;
    logic           Reset;
    logic [NB-1:0]  Btn_n;
    logic [SWW-1:0] SW;
    logic [NB-1:0]  Level;
    logic [NB-1:0]  Press;
    logic [NB-1:0]  Release;
    logic [SWW-1:0] SW_sync;

    input_conditioner #(
        .NUM_BTN        (NB),
        .DEBOUNCE_CYCLES(DEB),
        .SW_WIDTH       (SWW)
    ) dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .Btn_n  (Btn_n),
        .SW     (SW),
        .Level  (Level),
        .Press  (Press),
        .Release(Release),
        .SW_sync(SW_sync)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        int             cyc;
        logic [NB-1:0]  lvl;
        logic [SWW-1:0] sw;
    } st_t;

    typedef struct {
        int            cyc;
        logic [NB-1:0] p;
        logic [NB-1:0] r;
    } ev_t;

    st_t            st_q[$];
    ev_t            ev_q[$];
    logic [NB-1:0]  bh[$];      // raw buttons by sampling edge, index 0 = edge -1
    logic [SWW-1:0] sh[$];      // raw switches by sampling edge, index 0 = edge 0
    logic [NB-1:0]  m_lvl;
    int             last_flip[NB];
    int             me;
    int             edge_n = 0;
    int             n_cmp = 0;
    int             n_bad = 0;
    int             np[NB], nr[NB], fp[NB], fr[NB];
    st_t            st_m;
    ev_t            ev_m;
    logic [NB-1:0]  b;
    logic [SWW-1:0] s;
    int             e0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge Clk or negedge Reset) begin
        if (!Reset) edge_n <= 0;
        else        edge_n <= edge_n + 1;
    end

    // Reference model: after reset the synchroniser looks unpressed/zero.
    task automatic model_reset();
        bh.delete();
        sh.delete();
        bh.push_back('1);
        bh.push_back('1);
        sh.push_back('0);
        m_lvl = '0;
        for (int i = 0; i < NB; i++) last_flip[i] = 0;
        me = 0;
        st_q.delete();
        ev_q.delete();
    endtask

    // Level flips at an edge when the last DEB samples (each two edges old)
    // all disagree with it, and all of them came after the previous flip.
    task automatic model_edge(input logic [NB-1:0] bv, input logic [SWW-1:0] sv);
        ev_t           ev;
        st_t           st;
        logic [NB-1:0] raw;
        bit            stable;
        me++;
        bh.push_back(bv);
        sh.push_back(sv);
        ev.cyc = me;
        ev.p   = '0;
        ev.r   = '0;
        for (int i = 0; i < NB; i++) begin
            if (me - last_flip[i] >= DEB) begin
                stable = 1'b1;
                for (int k = 0; k < DEB; k++) begin
                    raw = bh[me - 1 - k];
                    if ((~raw[i]) == m_lvl[i]) stable = 1'b0;
                end
                if (stable) begin
                    m_lvl[i]     = ~m_lvl[i];
                    last_flip[i] = me;
                    if (m_lvl[i]) ev.p[i] = 1'b1;
                    else          ev.r[i] = 1'b1;
                end
            end
        end
        if ((ev.p | ev.r) != '0) ev_q.push_back(ev);
        st.cyc = me;
        st.lvl = m_lvl;
        st.sw  = sh[me - 1];
        st_q.push_back(st);
    endtask

    task automatic drive(input logic [NB-1:0] bv, input logic [SWW-1:0] sv);
        Btn_n = bv;
        SW    = sv;
        model_edge(bv, sv);
    endtask

    task automatic step(input logic [NB-1:0] bv, input logic [SWW-1:0] sv);
        @(negedge Clk);
        #1;
        drive(bv, sv);
    endtask

    task automatic clear_obs();
        for (int i = 0; i < NB; i++) begin
            np[i] = 0; nr[i] = 0; fp[i] = -1; fr[i] = -1;
        end
    endtask

    task automatic step_obs(input logic [NB-1:0] bv, input logic [SWW-1:0] sv);
        step(bv, sv);
        @(posedge Clk);
        #1;
        for (int i = 0; i < NB; i++) begin
            if (Press[i]) begin
                np[i]++;
                if (fp[i] < 0) fp[i] = edge_n;
            end
            if (Release[i]) begin
                nr[i]++;
                if (fr[i] < 0) fr[i] = edge_n;
            end
        end
    endtask

    task automatic do_reset(input logic [NB-1:0] bv, input logic [SWW-1:0] sv);
        @(negedge Clk);
        #1;
        Btn_n = bv;
        SW    = sv;
        Reset = 1'b0;
        #1;
        chk("reset_Level",   Level,   '0);
        chk("reset_Press",   Press,   '0);
        chk("reset_Release", Release, '0);
        chk("reset_SW_sync", SW_sync, '0);
        model_reset();
        @(negedge Clk);
        #1;
        Reset = 1'b1;
        drive(bv, sv);
    endtask

    // Monitor: compares every DUT cycle against the model's queued expectations.
    always @(negedge Clk) begin
        if (Reset && edge_n > 0) begin
            if (st_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL state_queue: got edge %0d expected a queued state", edge_n);
            end else begin
                st_m = st_q.pop_front();
                chk("state_cycle", edge_n,  st_m.cyc);
                chk("Level",       Level,   st_m.lvl);
                chk("SW_sync",     SW_sync, st_m.sw);
            end
            if ((Press | Release) != '0 || (ev_q.size() > 0 && ev_q[0].cyc <= edge_n)) begin
                if (ev_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_pulse: got Press=%b Release=%b expected none", Press, Release);
                end else begin
                    ev_m = ev_q.pop_front();
                    chk("pulse_cycle", edge_n,  ev_m.cyc);
                    chk("Press",       Press,   ev_m.p);
                    chk("Release",     Release, ev_m.r);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        Reset = 1'b0;
        Btn_n = '1;
        SW    = '0;
        model_reset();
        repeat (2) @(negedge Clk);
        do_reset(2'b11, 8'h00);
        repeat (3) step(2'b11, 8'h00);

        // Clean press of button 0
        clear_obs();
        step_obs(2'b10, 8'h00);
        e0 = me;
        repeat (19) step_obs(2'b10, 8'h00);
        chk("t2_press_latency", fp[0] - e0 + 1, DEB + 2);
        chk("t2_press_count",   np[0], 1);
        chk("t2_release_count", nr[0], 0);
        chk("t2_level",         Level, 2'b01);

        // Clean release of button 0, then a one-cycle glitch
        clear_obs();
        step_obs(2'b11, 8'h00);
        e0 = me;
        repeat (11) step_obs(2'b11, 8'h00);
        chk("t4_release_latency", fr[0] - e0 + 1, DEB + 2);
        chk("t4_release_count",   nr[0], 1);
        chk("t4_press_count",     np[0], 0);
        clear_obs();
        step_obs(2'b10, 8'h00);
        repeat (10) step_obs(2'b11, 8'h00);
        chk("t4_glitch_press",   np[0], 0);
        chk("t4_glitch_release", nr[0], 0);

        // Bouncing button 1 then settling pressed
        clear_obs();
        for (int k = 0; k < 12; k++) begin
            b    = 2'b11;
            b[1] = ((k / 2) % 2) != 0;
            step_obs(b, 8'h00);
        end
        step_obs(2'b01, 8'h00);
        e0 = me;
        repeat (15) step_obs(2'b01, 8'h00);
        chk("t3_press_count",   np[1], 1);
        chk("t3_press_latency", fp[1] - e0 + 1, DEB + 2);
        chk("t3_release_count", nr[1], 0);

        // Simultaneous press, switch sync latency
        repeat (10) step_obs(2'b11, 8'h00);
        clear_obs();
        step_obs(2'b00, 8'h3C);
        e0 = me;
        chk("t5_sw_edge1", SW_sync, 8'h00);
        step_obs(2'b00, 8'h3C);
        chk("t5_sw_edge2", SW_sync, 8'h3C);
        repeat (8) step_obs(2'b00, 8'h3C);
        chk("t5_same_cycle",    fp[1], fp[0]);
        chk("t5_press_latency", fp[0] - e0 + 1, DEB + 2);
        chk("t5_press_count0",  np[0], 1);
        chk("t5_press_count1",  np[1], 1);

        // Asynchronous reset mid-run with buttons pressed
        do_reset(2'b00, 8'hA5);
        repeat (10) step_obs(2'b00, 8'hA5);

        // Reset in the middle of a debounce count with button 0 held
        repeat (10) step_obs(2'b11, 8'hA5);
        clear_obs();
        repeat (4) step_obs(2'b10, 8'hA5);
        chk("t6_pre_reset_level", Level, 2'b00);
        do_reset(2'b10, 8'hA5);
        clear_obs();
        repeat (10) step_obs(2'b10, 8'hA5);
        chk("t6_press_after_reset", fp[0], DEB + 2);
        chk("t6_press_count",       np[0], 1);

        // Randomised run against the model
        b = 2'b11;
        s = 8'h00;
        repeat (800) begin
            for (int i = 0; i < NB; i++) begin
                if ($urandom_range(0, 7) == 0) b[i] = ~b[i];
            end
            if ($urandom_range(0, 3) == 0) s = 8'($urandom);
            step_obs(b, s);
        end
        repeat (10) step_obs(2'b11, s);
        chk("events_drained", ev_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
